// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: byte-wide memory read port, decode handshake and redirect input.
interface fetch_stage_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [23:0] f_to_d_reg;
    logic        f_valid;
    logic        d_ready;
    logic [15:0] f_pc;
    logic [1:0]  f_len;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, f_to_d_reg, f_valid, f_pc, f_len,
        input  mem_rdata, mem_ack, d_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  mem_req, mem_addr, f_to_d_reg, f_valid, f_pc, f_len,
        output mem_rdata, mem_ack, d_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// 6502 fetch stage: loads PC from the reset vector, then fetches and sizes instructions
// byte by byte and hands {opcode,op1,op2} to decode; execute may redirect the PC.
module fetch_stage #(
    parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH_OP, FETCH_B1, FETCH_B2, OUT, DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] f_pc_q, f_pc_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic [7:0]  opc_q, opc_d, op1_q, op1_d, op2_q, op2_d;
    logic [1:0]  len_q, len_d;
    logic        req;
    logic [15:0] addr;
    logic        redir;
    logic        take;

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = op[3:0];
        hi = op[7:4];
        case (lo)
            4'h0: begin
                if (hi == 4'h0 || hi == 4'h4 || hi == 4'h6) op_len = 2'd1;
                else if (hi == 4'h2)                        op_len = 2'd3;
                else                                        op_len = 2'd2;
            end
            4'h1, 4'h2, 4'h4, 4'h5, 4'h6: op_len = 2'd2;
            4'h9:                         op_len = hi[0] ? 2'd3 : 2'd2;
            4'hC, 4'hD, 4'hE:             op_len = 2'd3;
            default:                      op_len = 2'd1;
        endcase
    endfunction

    always_comb begin
        req  = 1'b0;
        addr = 16'h0000;
        case (state_q)
            VEC_LO:                       begin req = 1'b1; addr = VEC_ADDR; end
            VEC_HI:                       begin req = 1'b1; addr = VEC_ADDR + 16'd1; end
            FETCH_OP, FETCH_B1, FETCH_B2: begin req = 1'b1; addr = pc_q; end
            DRAIN:                        begin req = 1'b1; addr = drain_addr_q; end
            default:                      ;
        endcase
    end

    assign redir = bus.redirect_valid && state_q != VEC_LO && state_q != VEC_HI;
    // A redirect wins over any data arriving in the same cycle.
    assign take  = req && bus.mem_ack && !redir;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        f_pc_d       = f_pc_q;
        drain_addr_d = drain_addr_q;
        opc_d        = opc_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        len_d        = len_q;
        case (state_q)
            VEC_LO: if (take) begin
                pc_d[7:0] = bus.mem_rdata;
                state_d   = VEC_HI;
            end
            VEC_HI: if (take) begin
                pc_d[15:8] = bus.mem_rdata;
                state_d    = FETCH_OP;
            end
            FETCH_OP: if (take) begin
                opc_d   = bus.mem_rdata;
                op1_d   = 8'h00;
                op2_d   = 8'h00;
                f_pc_d  = pc_q;
                pc_d    = pc_q + 16'd1;
                len_d   = op_len(bus.mem_rdata);
                state_d = (len_d == 2'd1) ? OUT : FETCH_B1;
            end
            FETCH_B1: if (take) begin
                op1_d   = bus.mem_rdata;
                pc_d    = pc_q + 16'd1;
                state_d = (len_q == 2'd2) ? OUT : FETCH_B2;
            end
            FETCH_B2: if (take) begin
                op2_d   = bus.mem_rdata;
                pc_d    = pc_q + 16'd1;
                state_d = OUT;
            end
            OUT:     if (bus.d_ready) state_d = FETCH_OP;
            DRAIN:   if (take)        state_d = FETCH_OP;
            default: state_d = VEC_LO;
        endcase
        // An unacked read must still complete on the bus, so park its address in DRAIN.
        if (redir) begin
            pc_d = bus.redirect_pc;
            if (req && !bus.mem_ack) begin
                state_d      = DRAIN;
                drain_addr_d = addr;
            end else begin
                state_d = FETCH_OP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= VEC_LO;
            pc_q         <= 16'h0000;
            f_pc_q       <= 16'h0000;
            drain_addr_q <= 16'h0000;
            opc_q        <= 8'h00;
            op1_q        <= 8'h00;
            op2_q        <= 8'h00;
            len_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            f_pc_q       <= f_pc_d;
            drain_addr_q <= drain_addr_d;
            opc_q        <= opc_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            len_q        <= len_d;
        end
    end

    assign bus.mem_req    = req && !rst;
    assign bus.mem_addr   = rst ? 16'h0000 : addr;
    assign bus.f_valid    = (state_q == OUT) && !rst;
    assign bus.f_to_d_reg = {opc_q, op1_q, op2_q};
    assign bus.f_pc       = f_pc_q;
    assign bus.f_len      = len_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: byte memory with programmable wait states, a reference model that
// walks memory by instruction length, and directed plus random stimulus.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus();
    fetch_stage #(.VEC_ADDR(16'hFFFC)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];
    logic [1:0] len_tab [0:255];

    // memory: ack once the chosen number of wait cycles has elapsed
    int wcnt = 0, wait_cur = 0, wait_fix = 0, wait_max = 3;
    bit rnd_mode = 1'b0;
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ack   = bus.mem_req && (wcnt >= wait_cur);
    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) begin
            wcnt     <= 0;
            wait_cur <= rnd_mode ? int'($urandom_range(0, wait_max)) : wait_fix;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!bus.f_valid && n < maxc) begin
            step();
            n++;
        end
        chk("valid_timeout", {63'd0, bus.f_valid}, 64'd1);
    endtask

    // reference model: next instruction address walks by length, jumps on redirect
    logic [15:0] mpc;
    logic [15:0] a1, a2;
    logic [23:0] exp_ins;
    logic [1:0]  el;
    int          xfers = 0, xfer_since_rst = 0;
    bit          pend = 1'b0, hold = 1'b0;
    logic [15:0] pend_addr;
    logic [42:0] hold_val;

    always @(negedge clk) begin
        if (rst) begin
            mpc            = {mem[16'hFFFD], mem[16'hFFFC]};
            xfer_since_rst = 0;
            pend           = 1'b0;
            hold           = 1'b0;
        end else begin
            if (pend) chk("addr_hold", {47'd0, bus.mem_req, bus.mem_addr}, {47'd0, 1'b1, pend_addr});
            if (hold) chk("out_hold", {21'd0, bus.f_valid, bus.f_to_d_reg, bus.f_pc, bus.f_len},
                          {21'd0, hold_val});
            if (bus.f_valid) chk("req_in_out", {63'd0, bus.mem_req}, 64'd0);
            if (bus.f_valid && bus.d_ready) begin
                a1      = mpc + 16'd1;
                a2      = mpc + 16'd2;
                el      = len_tab[mem[mpc]];
                exp_ins = {mem[mpc], (el > 2'd1) ? mem[a1] : 8'h00, (el > 2'd2) ? mem[a2] : 8'h00};
                chk("xfer", {22'd0, bus.f_to_d_reg, bus.f_pc, bus.f_len}, {22'd0, exp_ins, mpc, el});
                mpc = mpc + 16'(el);
                xfers++;
                xfer_since_rst++;
            end
            if (bus.redirect_valid && xfer_since_rst > 0) mpc = bus.redirect_pc;
            pend      = bus.mem_req && !bus.mem_ack;
            pend_addr = bus.mem_addr;
            hold      = bus.f_valid && !bus.d_ready && !bus.redirect_valid;
            hold_val  = {bus.f_valid, bus.f_to_d_reg, bus.f_pc, bus.f_len};
        end
    end

    initial begin
        int n;
        int x0;
        logic [41:0] rec;
        logic [3:0] lo, hi;
        for (int op = 0; op < 256; op++) begin
            lo = 4'(op);
            hi = 4'(op >> 4);
            if (lo inside {4'h3, 4'h7, 4'h8, 4'hA, 4'hB, 4'hF}) len_tab[op] = 2'd1;
            else if (lo inside {4'hC, 4'hD, 4'hE})               len_tab[op] = 2'd3;
            else if (lo == 4'h9)                                  len_tab[op] = hi[0] ? 2'd3 : 2'd2;
            else if (lo == 4'h0)                                  len_tab[op] = (hi inside {4'h0, 4'h4, 4'h6}) ? 2'd1
                                                                             : (hi == 4'h2) ? 2'd3 : 2'd2;
            else                                                  len_tab[op] = 2'd2;
        end
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
        mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h42; mem[16'hC002] = 8'hEA;
        mem[16'hC003] = 8'h4C; mem[16'hC004] = 8'h34; mem[16'hC005] = 8'h12;
        mem[16'hC006] = 8'h8D; mem[16'hC007] = 8'h00; mem[16'hC008] = 8'h02;
        mem[16'hC009] = 8'hA9; mem[16'hC00A] = 8'h55;
        mem[16'h8000] = 8'h20; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h90;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12; mem[16'h0001] = 8'hEA;

        bus.d_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0000;
        step(); step();
        chk("rst_outs", {bus.mem_req, bus.f_valid, bus.mem_addr, bus.f_to_d_reg, bus.f_pc, bus.f_len}, 64'd0);

        // reset vector and first instruction latency
        rst = 1'b0; #1;
        chk("vec_lo", {47'd0, bus.mem_req, bus.mem_addr}, {47'd0, 1'b1, 16'hFFFC});
        step(); chk("vec_hi", bus.mem_addr, 16'hFFFD);
        step(); chk("first_pc", bus.mem_addr, 16'hC000);
        chk("no_valid", {63'd0, bus.f_valid}, 64'd0);
        bus.d_ready = 1'b1;
        wait_valid(20, n); chk("lat_a9", n, 2);
        chk("ins_a9", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, {24'hA94200, 16'hC000, 2'd2});
        step(); wait_valid(20, n); chk("lat_ea", n, 1);
        chk("ins_ea", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, {24'hEA0000, 16'hC002, 2'd1});
        step(); wait_valid(20, n); chk("lat_4c", n, 3);
        chk("ins_4c", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, {24'h4C3412, 16'hC003, 2'd3});
        step(); bus.d_ready = 1'b0;
        chk("next_c006", bus.mem_addr, 16'hC006);

        // backpressure in OUT
        wait_valid(20, n);
        rec = {bus.f_to_d_reg, bus.f_pc, bus.f_len};
        chk("ins_8d", rec, {24'h8D0002, 16'hC006, 2'd3});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stable", {20'd0, bus.f_valid, bus.mem_req, rec}, {20'd0, 1'b1, 1'b0, {bus.f_to_d_reg, bus.f_pc, bus.f_len}});
            chk("bp_data", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, rec);
        end
        wait_fix = 3; bus.d_ready = 1'b1;
        step(); bus.d_ready = 1'b0;
        chk("bp_release", {47'd0, bus.f_valid, bus.mem_addr}, {47'd0, 1'b0, 16'hC009});

        // redirect while the B1 read is waiting
        n = 0;
        while (bus.mem_addr != 16'hC00A && n < 20) begin step(); n++; end
        chk("reach_b1", bus.mem_addr, 16'hC00A);
        chk("b1_waiting", {63'd0, bus.mem_ack}, 64'd0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h8000;
        step(); bus.redirect_valid = 1'b0;
        chk("drain_hold", {47'd0, bus.mem_req, bus.mem_addr}, {47'd0, 1'b1, 16'hC00A});
        n = 0;
        while (bus.mem_addr != 16'h8000 && n < 20) begin
            chk("drain_no_valid", {63'd0, bus.f_valid}, 64'd0);
            step(); n++;
        end
        chk("redir_addr", bus.mem_addr, 16'h8000);
        wait_valid(40, n);
        chk("ins_8000", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, {24'h200090, 16'h8000, 2'd3});

        // redirect from OUT to FFFE, operands straddle the wrap
        wait_fix = 0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFE;
        step(); bus.redirect_valid = 1'b0;
        chk("redir_drop_valid", {63'd0, bus.f_valid}, 64'd0);
        wait_valid(20, n);
        chk("ins_wrap", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, {24'hAD3412, 16'hFFFE, 2'd3});
        bus.d_ready = 1'b1;
        step();
        chk("wrap_next", bus.mem_addr, 16'h0001);

        // random backpressure, waits and redirects against the model
        x0 = xfers;
        rnd_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus.d_ready        = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 25) == 0);
            bus.redirect_pc    = 16'($urandom);
            step();
        end
        bus.redirect_valid = 1'b0;
        chk("rand_progress", {63'd0, xfers > x0 + 100}, 64'd1);

        // reset in FETCH_B2
        rnd_mode = 1'b0; wait_fix = 0; bus.d_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hC003;
        step(); bus.redirect_valid = 1'b0;
        n = 0;
        while (!(bus.mem_req && bus.mem_addr == 16'hC005) && n < 30) begin step(); n++; end
        chk("reach_b2", bus.mem_addr, 16'hC005);
        rst = 1'b1;
        step();
        chk("rst_b2_outs", {bus.mem_req, bus.f_valid, bus.mem_addr, bus.f_to_d_reg, bus.f_pc, bus.f_len}, 64'd0);
        rst = 1'b0; #1;
        chk("rst_b2_vec", {47'd0, bus.mem_req, bus.mem_addr}, {47'd0, 1'b1, 16'hFFFC});

        // reset in OUT
        bus.d_ready = 1'b0;
        wait_valid(20, n);
        chk("pre_rst_out", bus.f_pc, 16'hC000);
        rst = 1'b1;
        step();
        chk("rst_out_valid", {63'd0, bus.f_valid}, 64'd0);
        rst = 1'b0; #1;
        chk("rst_out_vec", bus.mem_addr, 16'hFFFC);
        bus.d_ready = 1'b1;
        wait_valid(20, n);
        chk("restart_ins", {bus.f_to_d_reg, bus.f_pc, bus.f_len}, {24'hA94200, 16'hC000, 2'd2});
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
